// File: rtl/rfg_axis_pkg.sv
// Shared definitions for the RFG AXIS byte-stream blocks: header layout,
// frame-tracker state encoding and length-field width.
package rfg_axis_pkg;

  // Width of the frame length field ({LENB, LENA}); 0 encodes 65536 bytes.
  localparam int RFG_LEN_W = 16;

  // Bit positions of the command flags inside the header byte.
  localparam int RFG_HDR_WRITE_BIT = 0;
  localparam int RFG_HDR_READ_BIT  = 1;

  // Header byte layout as sent by the host.
  typedef struct packed {
    logic [3:0] vchannel;
    logic       rsvd;
    logic       incr;
    logic       read;
    logic       write;
  } rfg_header_t;

  // Position inside an RFG command frame.
  typedef enum logic [2:0] {
    HEADER,
    ADDRESS,
    LENA,
    LENB,
    PAYLOAD
  } rfg_frame_state_t;

endpackage

// File: rtl/rfg_frame_tracker.sv
// Follows an RFG command frame byte by byte and flags the byte that ends it.
// frame_last_o describes the byte currently on byte_i (combinational); state
// only advances when xfer_i reports that the byte was actually transferred.
module rfg_frame_tracker
  import rfg_axis_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_i,
  input  logic       xfer_i,
  output logic       frame_last_o
);

  rfg_frame_state_t     state_q, state_d;
  logic                 write_q, write_d;
  logic [7:0]           lena_q, lena_d;
  logic [RFG_LEN_W-1:0] cnt_q, cnt_d;

  // Decide whether the byte currently presented closes the frame.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    frame_last_o = 1'b0;
    case (state_q)
      HEADER:  frame_last_o = !(byte_i[RFG_HDR_WRITE_BIT] | byte_i[RFG_HDR_READ_BIT]);
      LENB:    frame_last_o = !write_q;
      PAYLOAD: frame_last_o = (cnt_q == RFG_LEN_W'(1));
      default: frame_last_o = 1'b0;
    endcase
  end

  // Next-state logic: move one field forward per transferred byte.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    lena_d  = lena_q;
    cnt_d   = cnt_q;
    if (xfer_i) begin
      case (state_q)
        HEADER: begin
          write_d = byte_i[RFG_HDR_WRITE_BIT];
          state_d = frame_last_o ? HEADER : ADDRESS;
        end
        ADDRESS: state_d = LENA;
        LENA: begin
          lena_d  = byte_i;
          state_d = LENB;
        end
        LENB: begin
          // Write wins over read when both flags are set; len=0 wraps to 65536.
          if (write_q) begin
            cnt_d   = {byte_i, lena_q};
            state_d = PAYLOAD;
          end else begin
            state_d = HEADER;
          end
        end
        PAYLOAD: begin
          cnt_d = cnt_q - RFG_LEN_W'(1);
          if (cnt_q == RFG_LEN_W'(1)) state_d = HEADER;
        end
        default: state_d = HEADER;
      endcase
    end
  end

  // Tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HEADER;
      write_q <= 1'b0;
      lena_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      write_q <= write_d;
      lena_q  <= lena_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/rfg_axis_frame_arbiter.sv
// Round-robin arbiter merging NUM_PORTS AXIS byte streams into one, holding the
// grant for a whole RFG command frame and tagging bytes with the source index.
// Optional feature: define RFG_ARB_TLAST_EN to add m_axis_tlast marking the
// last byte of each frame.
module rfg_axis_frame_arbiter
  import rfg_axis_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int ID_DEST_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_PORTS*8-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS-1:0]     s_axis_tvalid,
  output logic [NUM_PORTS-1:0]     s_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [ID_DEST_WIDTH-1:0] m_axis_tid,
  output logic                     arb_busy,
  output logic [NUM_PORTS-1:0]     arb_grant
`ifdef RFG_ARB_TLAST_EN
  ,
  output logic                     m_axis_tlast
`endif
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  logic                 busy_q, busy_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  idx_t                 idx_q, idx_d;
  idx_t                 rr_q, rr_d;

  logic pick_found;
  idx_t pick_idx;
  logic xfer;
  logic frame_last;

  // Round-robin search: first requesting port at or after the rr pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!pick_found && s_axis_tvalid[idx_t'((int'(rr_q) + k) % NUM_PORTS)]) begin
        pick_found = 1'b1;
        pick_idx   = idx_t'((int'(rr_q) + k) % NUM_PORTS);
      end
    end
  end

  // Pass-through datapath from the granted port; idle ports see tready=0.
  always_comb begin
    m_axis_tdata  = busy_q ? s_axis_tdata[8*idx_q +: 8] : 8'h00;
    m_axis_tvalid = busy_q & s_axis_tvalid[idx_q];
    s_axis_tready = grant_q & {NUM_PORTS{m_axis_tready}};
    m_axis_tid    = '0;
    m_axis_tid[IDX_W-1:0] = idx_q;
  end

  assign xfer      = m_axis_tvalid & m_axis_tready;
  assign arb_busy  = busy_q;
  assign arb_grant = grant_q;

  rfg_frame_tracker u_tracker (
    .clk          (aclk),
    .rst_n        (aresetn),
    .byte_i       (m_axis_tdata),
    .xfer_i       (xfer),
    .frame_last_o (frame_last)
  );

`ifdef RFG_ARB_TLAST_EN
  assign m_axis_tlast = m_axis_tvalid & frame_last;
`endif

  // Grant control: lock on a request when idle, release after the frame's last byte.
  always_comb begin
    busy_d  = busy_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    if (!busy_q) begin
      if (pick_found) begin
        busy_d  = 1'b1;
        grant_d = NUM_PORTS'(1) << pick_idx;
        idx_d   = pick_idx;
      end
    end else if (xfer && frame_last) begin
      busy_d  = 1'b0;
      grant_d = '0;
      idx_d   = '0;
      rr_d    = idx_t'((int'(idx_q) + 1) % NUM_PORTS);
    end
  end

  // Grant, tid and round-robin pointer registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy_q  <= 1'b0;
      grant_q <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_rfg_axis_frame_arbiter.sv
// Self-checking bench for rfg_axis_frame_arbiter: directed frame scenarios plus
// randomized traffic, compared every cycle against a frame-level reference model.
module tb_rfg_axis_frame_arbiter;
  import rfg_axis_pkg::*;

  localparam int NP  = 2;
  localparam int IDW = 8;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [NP*8-1:0] s_axis_tdata;
  logic [NP-1:0]   s_axis_tvalid;
  logic [NP-1:0]   s_axis_tready;
  logic [7:0]      m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [IDW-1:0]  m_axis_tid;
  logic            arb_busy;
  logic [NP-1:0]   arb_grant;
`ifdef RFG_ARB_TLAST_EN
  logic            m_axis_tlast;
`endif

  always #5 aclk = ~aclk;

  rfg_axis_frame_arbiter #(.NUM_PORTS(NP), .ID_DEST_WIDTH(IDW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tid    (m_axis_tid),
    .arb_busy      (arb_busy),
    .arb_grant     (arb_grant)
`ifdef RFG_ARB_TLAST_EN
    ,
    .m_axis_tlast  (m_axis_tlast)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Source byte queues, sent-stream copies, handshake flags, sink behaviour.
  logic [7:0]  src_q[NP][$];
  logic [7:0]  exp_stream[NP][$];
  logic [NP-1:0] xfer_seen = '0;
  int gap_pct    = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
  bit mon_en     = 1'b0;
  int cyc        = 0;

  // Observed DUT transfers and grant events.
  typedef struct {
    int         tid;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } log_t;
  log_t xlog[$];
  int   grant_log[$];
  int   fall_cyc = -1;
  logic prev_busy = 1'b0;
  logic [NP-1:0] prev_grant = '0;

  // Reference model: frame-level view (owner port, byte position, frame length).
  bit         md_busy   = 1'b0;
  int         md_g      = 0;
  int         md_rr     = 0;
  int         md_pos    = 0;
  int         md_paylen = 0;
  bit         md_write  = 1'b0;
  logic [7:0] md_lena   = 8'h00;

  // Directed expectations.
  logic [7:0] s1_data[10] = '{8'h03, 8'h10, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h02, 8'h20, 8'h01, 8'h00};
  int         s1_tid [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  logic [7:0] s3_data[7]  = '{8'h01, 8'h40, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
  logic [7:0] s5_data[4]  = '{8'h02, 8'h30, 8'h01, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // True when byte b, at the model's current position, completes the frame.
  function automatic bit md_is_last(input logic [7:0] b);
    rfg_header_t h;
    h = rfg_header_t'(b);
    if (md_pos == 0) return !(h.write || h.read);
    if (md_pos == 3) return !md_write;
    if (md_pos >= 4) return (md_pos - 3) == md_paylen;
    return 1'b0;
  endfunction

  task automatic monitor_cycle();
    logic [NP-1:0] exp_grant;
    logic [NP-1:0] exp_ready;
    logic          exp_mv;
    logic [7:0]    b;
    bit            last;
    log_t          e;
    rfg_header_t   h;
    bit            found;
    int            len16;

    exp_grant = md_busy ? (NP'(1) << md_g) : '0;
    exp_mv    = md_busy && s_axis_tvalid[md_g];
    exp_ready = (md_busy && m_axis_tready) ? exp_grant : '0;
    b         = s_axis_tdata[8*md_g +: 8];
    last      = exp_mv && md_is_last(b);

    check("arb_busy", arb_busy, md_busy);
    check("arb_grant", arb_grant, exp_grant);
    check("m_tvalid", m_axis_tvalid, exp_mv);
    check("s_tready", s_axis_tready, exp_ready);
    if (exp_mv) begin
      check("m_tdata", m_axis_tdata, b);
      check("m_tid", m_axis_tid, md_g);
`ifdef RFG_ARB_TLAST_EN
      check("m_tlast", m_axis_tlast, last);
`endif
    end

    // Record what the DUT actually did.
    if (m_axis_tvalid && m_axis_tready) begin
      e.tid  = int'(m_axis_tid);
      e.data = m_axis_tdata;
`ifdef RFG_ARB_TLAST_EN
      e.last = m_axis_tlast;
`else
      e.last = 1'b0;
`endif
      e.cyc  = cyc;
      xlog.push_back(e);
    end
    if (prev_grant == '0 && arb_grant != '0) grant_log.push_back(int'(arb_grant));
    if (prev_busy && !arb_busy) fall_cyc = cyc;
    prev_grant = arb_grant;
    prev_busy  = arb_busy;
    xfer_seen  = s_axis_tvalid & s_axis_tready;

    // Advance the model to the next cycle.
    if (!md_busy) begin
      found = 1'b0;
      for (int k = 0; k < NP; k++) begin
        if (!found && s_axis_tvalid[(md_rr + k) % NP]) begin
          found   = 1'b1;
          md_busy = 1'b1;
          md_g    = (md_rr + k) % NP;
          md_pos  = 0;
        end
      end
    end else if (exp_mv && m_axis_tready) begin
      if (last) begin
        md_busy = 1'b0;
        md_rr   = (md_g + 1) % NP;
      end else begin
        h = rfg_header_t'(b);
        if (md_pos == 0) md_write = h.write;
        if (md_pos == 2) md_lena = b;
        if (md_pos == 3) begin
          len16     = int'({b, md_lena});
          md_paylen = (len16 == 0) ? 65536 : len16;
        end
        md_pos++;
      end
    end
  endtask

  // Compare process: evaluate outputs mid-cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (aresetn === 1'b1 && mon_en) monitor_cycle();
      else xfer_seen = '0;
    end
  end

  // Stimulus driver: consume handshaken bytes, then present the next ones.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (xfer_seen[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        xfer_seen[p] = 1'b0;
        if (src_q[p].size() > 0 && $urandom_range(99) >= gap_pct) begin
          s_axis_tvalid[p]         = 1'b1;
          s_axis_tdata[8*p +: 8]   = src_q[p][0];
        end else begin
          s_axis_tvalid[p]         = 1'b0;
          s_axis_tdata[8*p +: 8]   = 8'($urandom);
        end
      end
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(1));
      endcase
    end
  end

  // Watchdog: the run must always terminate.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input int p, input logic [7:0] b);
    src_q[p].push_back(b);
    exp_stream[p].push_back(b);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge aclk);
      #1;
      n++;
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && !md_busy;
    end
    check({name, "_drained"}, done, 1'b1);
    repeat (2) @(negedge aclk);
    #1;
  endtask

  task automatic clear_logs();
    xlog.delete();
    grant_log.delete();
    fall_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},   arb_busy, 1'b0);
    check({name, "_grant"},  arb_grant, '0);
    check({name, "_tready"}, s_axis_tready, '0);
    check({name, "_tvalid"}, m_axis_tvalid, 1'b0);
    check({name, "_tid"},    m_axis_tid, '0);
  endtask

  int n_other;
  int ptr[NP];
  int t;
  int len;
  rfg_header_t hg;

  initial begin
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge aclk);
    #1;
    aresetn = 1'b1;
    mon_en  = 1'b1;

    // 1: write frame from port 0 ahead of a concurrent read from port 1.
    clear_logs();
    for (int i = 0; i < 6; i++) push(0, s1_data[i]);
    for (int i = 6; i < 10; i++) push(1, s1_data[i]);
    wait_drain(200, "s1");
    check("s1_count", xlog.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < xlog.size()) begin
        check("s1_tid", xlog[i].tid, s1_tid[i]);
        check("s1_data", xlog[i].data, s1_data[i]);
`ifdef RFG_ARB_TLAST_EN
        check("s1_tlast", xlog[i].last, (i == 5 || i == 9));
`endif
      end
    end

    // 2: back-to-back no-op frames from both ports alternate with one bubble.
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      push(0, 8'h00);
      push(1, 8'h00);
    end
    wait_drain(200, "s2");
    check("s2_grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) check("s2_grant_seq", grant_log[i], (i % 2 == 0) ? 1 : 2);
    check("s2_count", xlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < xlog.size()) begin
        check("s2_tid", xlog[i].tid, i % 2);
        if (i > 0) check("s2_spacing", xlog[i].cyc - xlog[i-1].cyc, 2);
`ifdef RFG_ARB_TLAST_EN
        check("s2_tlast", xlog[i].last, 1'b1);
`endif
      end
    end

    // 3: write len=3 under a toggling sink.
    clear_logs();
    ready_mode = 1;
    for (int i = 0; i < 7; i++) push(0, s3_data[i]);
    wait_drain(200, "s3");
    ready_mode = 0;
    check("s3_count", xlog.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < xlog.size()) check("s3_data", xlog[i].data, s3_data[i]);
    if (xlog.size() > 0) check("s3_busy_fall", fall_cyc, xlog[xlog.size()-1].cyc + 1);

    // 4: write len=0 carries 65536 payload bytes under one grant.
    clear_logs();
    push(1, 8'h01); push(1, 8'h00); push(1, 8'h00); push(1, 8'h00);
    for (int i = 0; i < 65536; i++) src_q[1].push_back(8'(i));
    wait_drain(70000, "s4");
    check("s4_count", xlog.size(), 65540);
    check("s4_grants", grant_log.size(), 1);
    n_other = 0;
    foreach (xlog[i]) if (xlog[i].tid != 1) n_other++;
    check("s4_tid_other", n_other, 0);
    if (xlog.size() > 0) check("s4_busy_fall", fall_cyc, xlog[xlog.size()-1].cyc + 1);
    exp_stream[1].delete();

    // 5: asynchronous reset in the middle of a payload.
    clear_logs();
    push(0, 8'h01); push(0, 8'h50); push(0, 8'h0A); push(0, 8'h00);
    for (int i = 0; i < 10; i++) push(0, 8'(8'hC0 + i));
    for (int n = 0; n < 100 && xlog.size() < 7; n++) @(negedge aclk);
    check("s5_in_payload", xlog.size() >= 7, 1'b1);
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("s5_reset");
    mon_en = 1'b0;
    src_q[0].delete();
    exp_stream[0].delete();
    s_axis_tvalid = '0;
    xfer_seen     = '0;
    md_busy       = 1'b0;
    md_rr         = 0;
    md_pos        = 0;
    prev_busy     = 1'b0;
    prev_grant    = '0;
    repeat (3) @(negedge aclk);
    #2;
    aresetn = 1'b1;
    mon_en  = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) push(1, s5_data[i]);
    wait_drain(200, "s5");
    check("s5_count", xlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < xlog.size()) begin
        check("s5_tid", xlog[i].tid, 1);
        check("s5_data", xlog[i].data, s5_data[i]);
      end
    end
    if (xlog.size() > 0) check("s5_busy_fall", fall_cyc, xlog[xlog.size()-1].cyc + 1);
    exp_stream[1].delete();

    // Randomized frames with source gaps and a random sink.
    clear_logs();
    gap_pct    = 30;
    ready_mode = 2;
    for (int p = 0; p < NP; p++) begin
      for (int f = 0; f < 10; f++) begin
        t  = $urandom_range(2);
        hg = rfg_header_t'(8'($urandom));
        case (t)
          0: begin hg.write = 1'b0; hg.read = 1'b0; push(p, 8'(hg)); end
          1: begin
            hg.write = 1'b0; hg.read = 1'b1;
            push(p, 8'(hg)); push(p, 8'($urandom)); push(p, 8'($urandom)); push(p, 8'($urandom));
          end
          default: begin
            hg.write = 1'b1;
            len = $urandom_range(1, 5);
            push(p, 8'(hg)); push(p, 8'($urandom)); push(p, 8'(len)); push(p, 8'h00);
            for (int i = 0; i < len; i++) push(p, 8'($urandom));
          end
        endcase
      end
    end
    wait_drain(5000, "rand");
    gap_pct    = 0;
    ready_mode = 0;
    for (int p = 0; p < NP; p++) ptr[p] = 0;
    foreach (xlog[i]) begin
      t = xlog[i].tid;
      check("rand_tid_range", (t >= 0 && t < NP) ? 1 : 0, 1);
      if (t >= 0 && t < NP) begin
        if (ptr[t] < exp_stream[t].size()) check("rand_data", xlog[i].data, exp_stream[t][ptr[t]]);
        ptr[t]++;
      end
    end
    for (int p = 0; p < NP; p++) check("rand_total", ptr[p], exp_stream[p].size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
